dmem_bus_arbiter: RTL and testbench

//  Shares the single data-memory/UART-MMIO port between two requesters: the core Memory-Writeback stage (CORE)
//  and the UART boot/DMA loader (UART). Sequences one outstanding transaction at a time over a req/gnt/rvalid port.

---
 rtl/dmem_bus_arbiter_pkg.sv | 27 ++
 rtl/dmem_bus_arbiter_watchdog.sv | 33 +++
 rtl/dmem_bus_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_arbiter_pkg.sv
// Shared types for the data-memory bus arbiter: FSM states, owner tag, latched memory command.
// Latency: none (types and constants only).
// Backpressure: none.
package dmem_bus_arbiter_pkg;

    localparam int DMEM_W = 32;
    localparam logic [DMEM_W-1:0] ARB_ABORT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } type_arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_UART = 1'b1
    } type_arb_owner_e;

    typedef struct packed {
        logic              we;
        logic [DMEM_W-1:0] addr;
        logic [DMEM_W-1:0] wdata;
        logic [3:0]        be;
    } type_mem_cmd_s;

endpackage

// File: rtl/dmem_bus_arbiter_watchdog.sv
// Transaction watchdog: aborts a REQ+RESP phase that runs TIMEOUT_CYC cycles, sticky arb_err (DMEM_ARB_TIMEOUT_EN).
// Latency: abort is combinational in the last allowed cycle; arb_err rises the cycle after.
// Backpressure: none; counts while active, clears whenever the arbiter is idle.
`ifdef DMEM_ARB_TIMEOUT_EN
module dmem_bus_arbiter_watchdog #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic resp_fire,
    output logic abort,
    output logic arb_err
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // The grant cycle counts as cycle 1, so done lands TIMEOUT_CYC cycles after the request.
    assign abort = active && !resp_fire && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= CW'(1);
            arb_err <= 1'b0;
        end else begin
            cnt <= active ? cnt + CW'(1) : CW'(1);
            if (abort) arb_err <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/dmem_bus_arbiter.sv
// Shares one data-memory/MMIO port between CORE and UART, one transaction in flight; watchdog under DMEM_ARB_TIMEOUT_EN.
// Latency: request seen cycle 0, mem_req cycle 1, done pulse the cycle after mem_rvalid (cycle 3 minimum).
// Backpressure: mem_req and command held until mem_gnt; CORE stalled until core_done; UART waits (starvation-bounded).
module dmem_bus_arbiter
    import dmem_bus_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [BUS_WIDTH-1:0] core_addr,
    input  logic [BUS_WIDTH-1:0] core_wdata,
    input  logic [3:0]           core_be,
    output logic [BUS_WIDTH-1:0] core_rdata,
    output logic                 core_done,
    output logic                 core_stall,
    input  logic                 uart_req,
    input  logic                 uart_we,
    input  logic [BUS_WIDTH-1:0] uart_addr,
    input  logic [BUS_WIDTH-1:0] uart_wdata,
    output logic [BUS_WIDTH-1:0] uart_rdata,
    output logic                 uart_done,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    output logic [3:0]           mem_be,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [BUS_WIDTH-1:0] mem_rdata,
    output logic                 arb_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    type_arb_state_e      state, state_nxt;
    type_arb_owner_e      owner;
    type_mem_cmd_s        cmd;
    logic [SW-1:0]        starve, starve_nxt;
    logic                 grant_core, grant_uart, uart_wait;
    logic                 resp_fire, abort, fin;
    logic [BUS_WIDTH-1:0] fin_dat;

    assign grant_uart = (state == IDLE) && uart_req && (!core_req || starve == STARVE_MAX);
    assign grant_core = (state == IDLE) && core_req && !grant_uart;
    assign uart_wait  = uart_req && !(owner == OWN_UART && state != IDLE);
    assign resp_fire  = (state == RESP) && mem_rvalid;
    assign fin        = resp_fire || abort;
    assign fin_dat    = resp_fire ? mem_rdata : ARB_ABORT_DATA;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_core || grant_uart) state_nxt = REQ;
            REQ:     if (abort) state_nxt = IDLE;
                     else if (mem_gnt) state_nxt = RESP;
            RESP:    if (fin) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        starve_nxt = starve;
        if (grant_uart || !uart_req)
            starve_nxt = '0;
        else if (uart_wait && starve != STARVE_MAX)
            starve_nxt = starve + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_CORE;
            cmd        <= '0;
            starve     <= '0;
            core_done  <= 1'b0;
            uart_done  <= 1'b0;
            core_rdata <= '0;
            uart_rdata <= '0;
        end else begin
            state     <= state_nxt;
            starve    <= starve_nxt;
            core_done <= fin && (owner == OWN_CORE);
            uart_done <= fin && (owner == OWN_UART);
            if (grant_core) begin
                owner <= OWN_CORE;
                cmd   <= '{we: core_we, addr: core_addr, wdata: core_wdata, be: core_be};
            end else if (grant_uart) begin
                owner <= OWN_UART;
                cmd   <= '{we: uart_we, addr: uart_addr, wdata: uart_wdata, be: 4'hF};
            end
            if (fin && owner == OWN_CORE) core_rdata <= fin_dat;
            if (fin && owner == OWN_UART) uart_rdata <= fin_dat;
        end
    end

    assign mem_req    = (state == REQ);
    assign mem_we     = cmd.we;
    assign mem_addr   = cmd.addr;
    assign mem_wdata  = cmd.wdata;
    assign mem_be     = cmd.be;
    assign core_stall = core_req && !core_done;

`ifdef DMEM_ARB_TIMEOUT_EN
    dmem_bus_arbiter_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .active    (state != IDLE),
        .resp_fire (resp_fire),
        .abort     (abort),
        .arb_err   (arb_err)
    );
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
    assign abort   = 1'b0;
    assign arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter with a small memory responder (programmable grant delay, rvalid gating).
// Latency: n/a.
// Backpressure: responder grants after gnt_delay cycles of mem_req; rvalid can be held off with rvalid_en.
module tb_dmem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_be;
    logic        core_done, core_stall;
    logic        uart_req, uart_we;
    logic [31:0] uart_addr, uart_wdata, uart_rdata;
    logic        uart_done;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        arb_err;

    int          n_chk = 0;
    int          n_err = 0;
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    logic        rvalid_en = 1'b1;
    logic        resp_pend = 1'b0;
    logic [31:0] rsp_data = '0;

    always #5 clk = ~clk;

    dmem_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_be    (core_be),
        .core_rdata (core_rdata),
        .core_done  (core_done),
        .core_stall (core_stall),
        .uart_req   (uart_req),
        .uart_we    (uart_we),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata),
        .uart_done  (uart_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .arb_err    (arb_err)
    );

    // Memory responder; pending response deliberately survives DUT reset.
    assign mem_gnt    = mem_req && (wait_cnt >= gnt_delay);
    assign mem_rvalid = resp_pend && rvalid_en;
    assign mem_rdata  = rsp_data;

    always @(posedge clk) begin
        if (mem_req && !mem_gnt) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_gnt)  resp_pend <= 1'b1;
        else if (mem_rvalid)     resp_pend <= 1'b0;
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
        uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;

        // Reset state
        repeat (2) step();
        chk_val("rst_mem_req",    32'(mem_req),   0);
        chk_val("rst_core_done",  32'(core_done), 0);
        chk_val("rst_uart_done",  32'(uart_done), 0);
        chk_val("rst_arb_err",    32'(arb_err),   0);
        chk_val("rst_core_rdata", core_rdata,     0);
        chk_val("rst_uart_rdata", uart_rdata,     0);
        rst = 1'b1;
        repeat (2) step();

        // 1: single CORE read, minimum latency
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h100; core_be = 4'hF; rsp_data = 32'hA5A5_0001;
        #1;
        chk_val("t1_stall_c0",   32'(core_stall), 1);
        chk_val("t1_memreq_c0",  32'(mem_req),    0);
        step();
        chk_val("t1_memreq_c1",  32'(mem_req),    1);
        chk_val("t1_addr_c1",    mem_addr,        32'h100);
        chk_val("t1_stall_c1",   32'(core_stall), 1);
        step();
        chk_val("t1_done_c2",    32'(core_done),  0);
        chk_val("t1_stall_c2",   32'(core_stall), 1);
        step();
        chk_val("t1_done_c3",    32'(core_done),  1);
        chk_val("t1_rdata_c3",   core_rdata,      32'hA5A5_0001);
        chk_val("t1_stall_c3",   32'(core_stall), 0);
        core_req = 1'b0;
        step();
        chk_val("t1_done_c4",    32'(core_done),  0);
        chk_val("t1_memreq_c4",  32'(mem_req),    0);
        step();

        // 2: simultaneous requests, CORE first, UART granted in CORE's done cycle
        core_req = 1'b1; core_addr = 32'h200;
        uart_req = 1'b1; uart_we = 1'b1; uart_addr = 32'h300; uart_wdata = 32'h1234_5678;
        rsp_data = 32'h0000_0011;
        step();
        chk_val("t2_core_first",  mem_addr, 32'h200);
        repeat (2) step();
        chk_val("t2_core_done",   32'(core_done), 1);
        chk_val("t2_core_rdata",  core_rdata,     32'h11);
        core_req = 1'b0; rsp_data = 32'h0000_0022;
        step();
        chk_val("t2_uart_addr",   mem_addr,       32'h300);
        chk_val("t2_uart_we",     32'(mem_we),    1);
        chk_val("t2_uart_wdata",  mem_wdata,      32'h1234_5678);
        chk_val("t2_uart_be",     32'(mem_be),    32'hF);
        repeat (2) step();
        chk_val("t2_uart_done",   32'(uart_done), 1);
        chk_val("t2_uart_rdata",  uart_rdata,     32'h22);
        uart_req = 1'b0; uart_we = 1'b0;
        step();
        chk_val("t2_uart_done_1", 32'(uart_done), 0);
        step();

        // 3: CORE requests continuously, UART starves until the limit
        core_req = 1'b1; core_addr = 32'h400; uart_req = 1'b1; uart_addr = 32'h500; rsp_data = 32'h33;
        for (int c = 1; c <= 15; c++) begin
            step();
            case (c)
                1, 4, 7: chk_val("t3_core_wins", mem_addr, 32'h400);
                10:      chk_val("t3_uart_wins", mem_addr, 32'h500);
                12: begin
                    chk_val("t3_uart_done",  32'(uart_done), 1);
                    chk_val("t3_uart_rdata", uart_rdata,     32'h33);
                end
                13: begin
                    chk_val("t3_starve_clr", mem_addr, 32'h400);
                    uart_req = 1'b0;
                end
                15: begin
                    chk_val("t3_core_done",  32'(core_done), 1);
                    core_req = 1'b0;
                end
                default: ;
            endcase
        end
        repeat (2) step();

        // 4: delayed grant, write command must hold steady
        gnt_delay = 5;
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'hCAFE_F00D; core_be = 4'h3;
        rsp_data = 32'h0000_BEEF;
        for (int c = 1; c <= 5; c++) begin
            step();
            chk_val("t4_req_hold",   32'(mem_req), 1);
            chk_val("t4_we_hold",    32'(mem_we),  1);
            chk_val("t4_addr_hold",  mem_addr,     32'h40);
            chk_val("t4_wdata_hold", mem_wdata,    32'hCAFE_F00D);
            chk_val("t4_be_hold",    32'(mem_be),  32'h3);
        end
        step();
        chk_val("t4_req_gnt_c6", 32'(mem_req),   1);
        step();
        chk_val("t4_done_c7",    32'(core_done), 0);
        step();
        chk_val("t4_done_c8",    32'(core_done), 1);
        core_req = 1'b0; core_we = 1'b0;
        step();
        chk_val("t4_done_c9",    32'(core_done), 0);
        chk_val("t4_memreq_c9",  32'(mem_req),   0);
        gnt_delay = 0;
        step();

        // 5: async reset while in RESP; late response ignored
        rvalid_en = 1'b0;
        core_req = 1'b1; core_addr = 32'h80; rsp_data = 32'h5555_AAAA;
        repeat (2) step();
        chk_val("t5_rdata_hold", core_rdata, 32'h0000_BEEF);
        step();
        rst = 1'b0;
        #1;
        chk_val("t5_rst_rdata",  core_rdata,     0);
        chk_val("t5_rst_memreq", 32'(mem_req),   0);
        chk_val("t5_rst_done",   32'(core_done), 0);
        step();
        rst = 1'b1; core_req = 1'b0; rvalid_en = 1'b1;
        step();
        chk_val("t5_no_done",    32'(core_done), 0);
        chk_val("t5_rdata_0",    core_rdata,     0);
        chk_val("t5_memreq_0",   32'(mem_req),   0);
        step();
        chk_val("t5_no_done_2",  32'(core_done), 0);

`ifdef DMEM_ARB_TIMEOUT_EN
        // 6: watchdog abort with no response
        step();
        rvalid_en = 1'b0;
        core_req = 1'b1; core_addr = 32'h44;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (c == 15) begin
                chk_val("t6_done_c15", 32'(core_done), 0);
                chk_val("t6_err_c15",  32'(arb_err),   0);
            end
        end
        step();
        chk_val("t6_done_c16",   32'(core_done), 1);
        chk_val("t6_rdata_c16",  core_rdata,     32'hDEAD_BEEF);
        chk_val("t6_err_c16",    32'(arb_err),   1);
        chk_val("t6_memreq_c16", 32'(mem_req),   0);
        core_req = 1'b0;
        repeat (3) step();
        chk_val("t6_err_sticky", 32'(arb_err),   1);
        chk_val("t6_done_once",  32'(core_done), 0);
        rst = 1'b0;
        #1;
        chk_val("t6_err_rst",    32'(arb_err),   0);
        step();
        rst = 1'b1;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
